// File: rtl/barrel_unshifter.sv
// Inverse rotator feeding a small valid/ready output FIFO.
// Optional output-handshake counter enabled by defining UNSHIFT_STATS_EN.
module barrel_unshifter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic                     in_dir,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [7:0]               stat_words
);

  localparam int AMT_W = $clog2(WIDTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // A left rotation by a equals a right rotation by (WIDTH - a) mod WIDTH.
  function automatic logic [WIDTH-1:0] rotate_right(input logic [WIDTH-1:0] d,
                                                    input logic [AMT_W-1:0] a);
    logic [2*WIDTH-1:0] dd;
    dd = {d, d} >> a;
    return dd[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_next_s;
  logic [WIDTH-1:0] unshifted_s;

  assign push_s = in_valid && in_ready_r;
  assign pop_s  = out_valid_r && out_ready;

  // Inverse rotation and next occupancy.
  always_comb begin
    unshifted_s  = in_data;
    count_next_s = count_r;
    if (in_dir) begin
      unshifted_s = rotate_right(in_data, in_amt);
    end else begin
      unshifted_s = rotate_right(in_data, {AMT_W{1'b0}} - in_amt);
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= unshifted_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r     <= count_next_s;
      in_ready_r  <= (count_next_s != FULL_CNT);
      out_valid_r <= (count_next_s != {CNT_W{1'b0}});
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = mem_r[rd_ptr_r];

`ifdef UNSHIFT_STATS_EN
  logic [7:0] stat_r;

  // Output handshake counter, wraps modulo 256.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_r <= 8'd0;
    end else if (pop_s) begin
      stat_r <= stat_r + 8'd1;
    end
  end

  assign stat_words = stat_r;
`else
  assign stat_words = 8'd0;
`endif

endmodule

// File: tb/tb_barrel_unshifter.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed vectors with literal expected values.
module tb_barrel_unshifter;
  localparam int W = 4;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_amt;
  logic       in_dir;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [7:0] stat_words;

  int checks = 0;
  int errors = 0;

  barrel_unshifter #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stat_words(stat_words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: undo the rotation with plain integer arithmetic.
  function automatic logic [3:0] unshift_m(input logic [3:0] d, input int a, input bit dir);
    int r;
    int v;
    int mask;
    mask = (1 << W) - 1;
    r = dir ? (a % W) : ((W - (a % W)) % W);
    v = int'(d);
    return 4'(((v >> r) | (v << (W - r))) & mask);
  endfunction

  logic [3:0] q[$];
  logic [7:0] stat_m = 8'd0;
  bit         pend = 1'b0;
  logic [6:0] pend_fields;

  always @(posedge rst) begin
    q.delete();
    stat_m = 8'd0;
    pend = 1'b0;
  end

  // Model update at the active edge, plus upstream hold-stable check.
  always @(posedge clk) begin
    bit push;
    bit pop;
    if (!rst) begin
      if (pend) begin
        chk("upstream_hold", {in_valid, in_data, in_amt, in_dir}, {1'b1, pend_fields});
      end
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      if (pop) begin
        void'(q.pop_front());
        stat_m = stat_m + 8'd1;
      end
      if (push) q.push_back(unshift_m(in_data, int'(in_amt), in_dir));
      pend = in_valid && !push;
      pend_fields = {in_data, in_amt, in_dir};
    end
  end

  // Compare DUT against the model every cycle on the inactive edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
`ifdef UNSHIFT_STATS_EN
      chk("stat_words", 32'(stat_words), 32'(stat_m));
`else
      chk("stat_words", 32'(stat_words), 32'd0);
`endif
    end
  end

  // Present a word and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] d, input logic [1:0] a, input logic dir);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 4'h0;
    in_amt = 2'd0;
    in_dir = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_stat", 32'(stat_words), 32'd0);
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // Directed inverse rotations.
    send(4'b0110, 2'd1, 1'b1);
    chk("left_inv_valid", 32'(out_valid), 32'd1);
    chk("left_inv_data", 32'(out_data), 32'(4'b0011));
    send(4'b1001, 2'd1, 1'b0);
    chk("right_inv_data", 32'(out_data), 32'(4'b0011));
    send(4'b1010, 2'd3, 1'b1);
    chk("amt3_data", 32'(out_data), 32'(4'b0101));
    send(4'b1100, 2'd0, 1'b0);
    chk("amt0_data", 32'(out_data), 32'(4'b1100));
    chk("model_pin", 32'(unshift_m(4'b0001, 1, 1'b0)), 32'(4'b0010));

    // Streaming at count=1.
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 2'(i), 1'(i >> 2));
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_ready", 32'(in_ready), 32'd1);
    end
    cycles(3);

    // Backpressure: third word must wait for the consumer.
    out_ready = 1'b0;
    send(4'h1, 2'd0, 1'b0);
    send(4'h2, 2'd0, 1'b0);
    chk("bp_full", 32'(in_ready), 32'd0);
    fork
      send(4'h3, 2'd0, 1'b0);
      begin
        cycles(2);
        chk("bp_head_held", 32'(out_data), 32'h1);
        out_ready = 1'b1;
      end
    join
    cycles(4);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Asynchronous reset with a full FIFO.
    out_ready = 1'b0;
    send(4'h5, 2'd0, 1'b0);
    send(4'h6, 2'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_stat", 32'(stat_words), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(4'hA, 2'd0, 1'b0);
    chk("post_rst_head", 32'(out_data), 32'hA);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;

    // 256 more handshakes on top of the one above: 257 since reset.
    for (int i = 0; i < 256; i++) begin
      send(4'(i), 2'(i >> 4), 1'(i >> 6));
    end
    cycles(3);
`ifdef UNSHIFT_STATS_EN
    chk("stat_wrap", 32'(stat_words), 32'd1);
`else
    chk("stat_wrap", 32'(stat_words), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
